// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode-side hazard interface: instruction fields in, stall/flush/forward controls and counters out.
// master = pipeline driving decode fields; slave = hazard controller.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int CNT_W  = 16
);
  localparam int FW = $clog2(DEPTH + 1);

  logic              dec_valid_i;
  logic [REG_AW-1:0] rs1_i;
  logic [REG_AW-1:0] rs2_i;
  logic [REG_AW-1:0] rd_i;
  logic              regwrite_i;
  logic              is_load_i;
  logic              redirect_i;
  logic              stall_o;
  logic              flush_o;
  logic [FW-1:0]     fwd1_o;
  logic [FW-1:0]     fwd2_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;

  modport master (
    output dec_valid_i, rs1_i, rs2_i, rd_i, regwrite_i, is_load_i, redirect_i,
    input  stall_o, flush_o, fwd1_o, fwd2_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  dec_valid_i, rs1_i, rs2_i, rd_i, regwrite_i, is_load_i, redirect_i,
    output stall_o, flush_o, fwd1_o, fwd2_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: in-flight writer scoreboard drives operand forwarding, load-use stalls and flushes.
// Controls are combinational from inputs and scoreboard; state advances on the falling clock edge.
module pipeline_hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 2,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int FW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              ld;
  } entry_t;

  entry_t           sb_q [1:DEPTH];
  entry_t           sb_d;
  logic [FW-1:0]    fwd1;
  logic [FW-1:0]    fwd2;
  logic             haz1;
  logic             haz2;
  logic             stall;
  logic             flush;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;

  // Walk oldest to youngest so the youngest matching writer wins.
  always_comb begin
    fwd1 = '0;
    fwd2 = '0;
    haz1 = 1'b0;
    haz2 = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (sb_q[k].vld && sb_q[k].wr && (sb_q[k].rd == hz.rs1_i) && (hz.rs1_i != '0)) begin
        fwd1 = FW'(k);
        haz1 = sb_q[k].ld && (k < LOAD_READY);
      end
      if (sb_q[k].vld && sb_q[k].wr && (sb_q[k].rd == hz.rs2_i) && (hz.rs2_i != '0)) begin
        fwd2 = FW'(k);
        haz2 = sb_q[k].ld && (k < LOAD_READY);
      end
    end
    if (!hz.dec_valid_i) begin
      fwd1 = '0;
      fwd2 = '0;
      haz1 = 1'b0;
      haz2 = 1'b0;
    end
  end

  assign flush = hz.redirect_i;
  assign stall = hz.dec_valid_i && (haz1 || haz2) && !hz.redirect_i;

  always_comb begin
    sb_d = '0;
    if (hz.dec_valid_i && !stall && !flush) begin
      sb_d.vld = 1'b1;
      sb_d.rd  = hz.rd_i;
      sb_d.wr  = hz.regwrite_i;
      sb_d.ld  = hz.is_load_i;
    end
  end

  assign stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  assign flush_cnt_d = (flush && (flush_cnt_q != '1)) ? flush_cnt_q + 1'b1 : flush_cnt_q;

  always_ff @(negedge clk) begin
    if (rst) begin
      sb_q        <= '{default: '0};
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      sb_q[1] <= sb_d;
      for (int k = 2; k <= DEPTH; k++) begin
        sb_q[k] <= sb_q[k-1];
      end
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_o     = stall;
  assign hz.flush_o     = flush;
  assign hz.fwd1_o      = fwd1;
  assign hz.fwd2_o      = fwd2;
  assign hz.stall_cnt_o = stall_cnt_q;
  assign hz.flush_cnt_o = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (DEPTH=3, LOAD_READY=2, CNT_W=4 to reach saturation quickly).
// Inputs change on the rising edge, outputs are sampled 1ns later, state moves on the falling edge.
module tb_pipeline_hazard_ctrl;
  logic clk;
  logic rst;

  pipeline_hazard_ctrl_if #(.REG_AW(5), .DEPTH(3), .CNT_W(4)) hz_if ();

  pipeline_hazard_ctrl #(.REG_AW(5), .DEPTH(3), .LOAD_READY(2), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       stall;
    logic       flush;
    logic [1:0] f1;
    logic [1:0] f2;
    logic [3:0] sc;
    logic [3:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   sc_m   = 0;
  int   fc_m   = 0;

  task automatic check_out();
    exp_t e;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL queue_empty: observed size %0d, expected >0", exp_q.size());
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      assert (hz_if.stall_o === e.stall) else begin
        errors++; $error("FAIL %s stall_o: observed %b expected %b", e.tag, hz_if.stall_o, e.stall);
      end
      checks++;
      assert (hz_if.flush_o === e.flush) else begin
        errors++; $error("FAIL %s flush_o: observed %b expected %b", e.tag, hz_if.flush_o, e.flush);
      end
      checks++;
      assert (hz_if.fwd1_o === e.f1) else begin
        errors++; $error("FAIL %s fwd1_o: observed %0d expected %0d", e.tag, hz_if.fwd1_o, e.f1);
      end
      checks++;
      assert (hz_if.fwd2_o === e.f2) else begin
        errors++; $error("FAIL %s fwd2_o: observed %0d expected %0d", e.tag, hz_if.fwd2_o, e.f2);
      end
      checks++;
      assert (hz_if.stall_cnt_o === e.sc) else begin
        errors++; $error("FAIL %s stall_cnt_o: observed %0d expected %0d", e.tag, hz_if.stall_cnt_o, e.sc);
      end
      checks++;
      assert (hz_if.flush_cnt_o === e.fc) else begin
        errors++; $error("FAIL %s flush_cnt_o: observed %0d expected %0d", e.tag, hz_if.flush_cnt_o, e.fc);
      end
    end
  endtask

  // One decode cycle: drive, queue the expectation, sample, advance the counter model, move to next rising edge.
  task automatic cyc(input string tag, input bit v, input int r1, input int r2, input int rd,
                     input bit wr, input bit ld, input bit rdr,
                     input bit e_st, input int e_f1, input int e_f2);
    exp_t e;
    hz_if.dec_valid_i = v;
    hz_if.rs1_i       = 5'(r1);
    hz_if.rs2_i       = 5'(r2);
    hz_if.rd_i        = 5'(rd);
    hz_if.regwrite_i  = wr;
    hz_if.is_load_i   = ld;
    hz_if.redirect_i  = rdr;
    e.tag   = tag;
    e.stall = e_st;
    e.flush = rdr;
    e.f1    = 2'(e_f1);
    e.f2    = 2'(e_f2);
    e.sc    = 4'(sc_m);
    e.fc    = 4'(fc_m);
    exp_q.push_back(e);
    #1;
    check_out();
    if (rst) begin
      sc_m = 0;
      fc_m = 0;
    end else begin
      if (e_st && sc_m < 15) sc_m++;
      if (rdr && fc_m < 15) fc_m++;
    end
    @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    hz_if.dec_valid_i = 1'b0;
    hz_if.rs1_i       = '0;
    hz_if.rs2_i       = '0;
    hz_if.rd_i        = '0;
    hz_if.regwrite_i  = 1'b0;
    hz_if.is_load_i   = 1'b0;
    hz_if.redirect_i  = 1'b0;
    @(posedge clk);
    @(posedge clk);

    // Reset: empty scoreboard, flush still follows redirect, counters held at 0.
    cyc("rst_redirect", 1, 5, 5, 1, 1, 0, 1, 0, 0, 0);
    rst = 1'b0;

    cyc("alu_first",   1, 1, 2, 5, 1, 0, 0, 0, 0, 0);
    cyc("alu_fwd",     1, 5, 1, 6, 1, 0, 0, 0, 1, 0);
    cyc("load_x7",     1, 0, 0, 7, 1, 1, 0, 0, 0, 0);
    cyc("load_use",    1, 7, 7, 8, 1, 0, 0, 1, 1, 1);
    cyc("load_fwd",    1, 7, 7, 8, 1, 0, 0, 0, 2, 2);
    cyc("write_x3_a",  1, 0, 0, 3, 1, 0, 0, 0, 0, 0);
    cyc("mid_fwd",     1, 8, 7, 9, 1, 0, 0, 0, 2, 0);
    cyc("write_x3_b",  1, 3, 9, 3, 1, 0, 0, 0, 2, 1);
    cyc("youngest",    1, 3, 0, 10, 1, 0, 0, 0, 1, 0);
    cyc("write_x0",    1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc("read_x0",     1, 0, 10, 11, 1, 0, 0, 0, 0, 2);
    cyc("load_x12",    1, 11, 0, 12, 1, 1, 0, 0, 1, 0);
    cyc("ld_redirect", 1, 12, 0, 13, 1, 0, 1, 0, 1, 0);
    cyc("killed_inst", 1, 13, 12, 0, 0, 0, 0, 0, 0, 2);
    cyc("dec_invalid", 0, 12, 12, 0, 0, 0, 0, 0, 0, 0);

    // Twenty load/use pairs push the 4-bit stall counter into saturation.
    for (int i = 0; i < 20; i++) begin
      cyc("sat_load",    1, 0, 0, 14, 1, 1, 0, 0, 0, 0);
      cyc("sat_stall",   1, 14, 0, 15, 1, 0, 0, 1, 1, 0);
      cyc("sat_release", 1, 14, 0, 15, 1, 0, 0, 0, 2, 0);
    end

    // Reset lands during a stall: the stalled consumer must not enter the scoreboard.
    cyc("pre_rst_load", 1, 0, 0, 14, 1, 1, 0, 0, 0, 0);
    rst = 1'b1;
    cyc("rst_in_stall", 1, 14, 0, 15, 1, 0, 0, 1, 1, 0);
    rst = 1'b0;
    cyc("post_rst",     1, 14, 0, 15, 1, 0, 0, 0, 0, 0);
    cyc("post_rst_fwd", 1, 15, 0, 16, 1, 0, 0, 0, 1, 0);
    cyc("redirect2",    1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc("flush_count",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
